// File: rtl/victim_cache_arbiter.sv
// Round-robin arbiter between the I-side and D-side L1s for the single victim cache request port.
// Keeps one transaction outstanding, routes the response to its owner, and keeps grant/hit statistics.
module victim_cache_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              i_req_valid_i,
   input  logic              i_req_evict_i,
   input  logic [ADDR_W-1:0] i_req_addr_i,
   input  logic [LINE_W-1:0] i_req_data_i,
   output logic              i_req_ready_o,
   output logic              i_rsp_valid_o,
   output logic              i_rsp_hit_o,
   output logic [LINE_W-1:0] i_rsp_data_o,
   input  logic              d_req_valid_i,
   input  logic              d_req_evict_i,
   input  logic [ADDR_W-1:0] d_req_addr_i,
   input  logic [LINE_W-1:0] d_req_data_i,
   output logic              d_req_ready_o,
   output logic              d_rsp_valid_o,
   output logic              d_rsp_hit_o,
   output logic [LINE_W-1:0] d_rsp_data_o,
   output logic              vc_req_valid_o,
   output logic              vc_req_evict_o,
   output logic [ADDR_W-1:0] vc_req_addr_o,
   output logic [LINE_W-1:0] vc_req_data_o,
   input  logic              vc_req_ready_i,
   input  logic              vc_rsp_valid_i,
   input  logic              vc_rsp_hit_i,
   input  logic [LINE_W-1:0] vc_rsp_data_i,
   output logic [31:0]       gnt_cnt_i_o,
   output logic [31:0]       gnt_cnt_d_o,
   output logic [31:0]       hit_cnt_o,
   output logic              protocol_err_o
);

   // state | meaning
   // IDLE  | pick a winner, pulse its ready, capture the request
   // ISSUE | present captured request to the victim cache until accepted
   // WAIT  | wait for the victim cache completion, register the result
   // RESP  | one-cycle response pulse to the owner
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic                last_gnt_q;   // 1 = d was granted last
   logic                owner_q;      // 1 = d owns the outstanding transaction
   logic                evict_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   data_q;
   logic                rsp_hit_q;
   logic [LINE_W-1:0]   rsp_data_q;
   logic [31:0]         gnt_cnt_i_q, gnt_cnt_d_q, hit_cnt_q;
   logic                err_q;

   logic                win_d;
   logic                accept;
   logic                rsp_take;
   logic                rsp_hit_n;
   logic [LINE_W-1:0]   rsp_data_n;
   logic                resp_active;

   // On a tie the requester not granted last time wins.
   assign win_d      = d_req_valid_i & (~i_req_valid_i | ~last_gnt_q);
   assign rsp_take   = (state_q == WAIT) & vc_rsp_valid_i;
   assign rsp_hit_n  = vc_rsp_hit_i & ~evict_q;
   assign rsp_data_n = rsp_hit_n ? vc_rsp_data_i : '0;

   always_comb begin
      state_d        = state_q;
      accept         = 1'b0;
      i_req_ready_o  = 1'b0;
      d_req_ready_o  = 1'b0;
      vc_req_valid_o = 1'b0;
      resp_active    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_req_valid_i | d_req_valid_i) begin
               accept        = 1'b1;
               i_req_ready_o = ~win_d;
               d_req_ready_o = win_d;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            vc_req_valid_o = 1'b1;
            if (vc_req_ready_i) state_d = WAIT;
         end
         WAIT: begin
            if (vc_rsp_valid_i) state_d = RESP;
         end
         RESP: begin
            resp_active = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_gnt_q  <= 1'b1;
         owner_q     <= 1'b0;
         evict_q     <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_data_q  <= '0;
         gnt_cnt_i_q <= '0;
         gnt_cnt_d_q <= '0;
         hit_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            last_gnt_q <= win_d;
            owner_q    <= win_d;
            evict_q    <= win_d ? d_req_evict_i : i_req_evict_i;
            addr_q     <= win_d ? d_req_addr_i  : i_req_addr_i;
            data_q     <= win_d ? d_req_data_i  : i_req_data_i;
            if (win_d) gnt_cnt_d_q <= gnt_cnt_d_q + 32'd1;
            else       gnt_cnt_i_q <= gnt_cnt_i_q + 32'd1;
         end
         if (rsp_take) begin
            rsp_hit_q  <= rsp_hit_n;
            rsp_data_q <= rsp_data_n;
            if (rsp_hit_n) hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         // Completions outside WAIT are dropped and flagged until reset.
         if (vc_rsp_valid_i && (state_q != WAIT)) err_q <= 1'b1;
      end
   end

   assign vc_req_evict_o = evict_q;
   assign vc_req_addr_o  = addr_q;
   assign vc_req_data_o  = data_q;

   assign i_rsp_valid_o = resp_active & ~owner_q;
   assign d_rsp_valid_o = resp_active & owner_q;
   assign i_rsp_hit_o   = i_rsp_valid_o & rsp_hit_q;
   assign d_rsp_hit_o   = d_rsp_valid_o & rsp_hit_q;
   assign i_rsp_data_o  = i_rsp_valid_o ? rsp_data_q : '0;
   assign d_rsp_data_o  = d_rsp_valid_o ? rsp_data_q : '0;

   assign gnt_cnt_i_o    = gnt_cnt_i_q;
   assign gnt_cnt_d_o    = gnt_cnt_d_q;
   assign hit_cnt_o      = hit_cnt_q;
   assign protocol_err_o = err_q;

endmodule

// File: tb/tb_victim_cache_arbiter.sv
// Directed bench for victim_cache_arbiter: vector table of full transactions plus
// hand-written tie-arbitration, protocol-error and reset-mid-WAIT sequences.
module tb_victim_cache_arbiter;

   localparam logic [127:0] L_A5   = {4{32'hA5A5A5A5}};
   localparam logic [127:0] L_DEAD = {4{32'hDEADBEEF}};

   logic         clk, rst_n;
   logic         i_req_valid, i_req_evict, i_req_ready, i_rsp_valid, i_rsp_hit;
   logic [31:0]  i_req_addr;
   logic [127:0] i_req_data, i_rsp_data;
   logic         d_req_valid, d_req_evict, d_req_ready, d_rsp_valid, d_rsp_hit;
   logic [31:0]  d_req_addr;
   logic [127:0] d_req_data, d_rsp_data;
   logic         vc_req_valid, vc_req_evict, vc_req_ready, vc_rsp_valid, vc_rsp_hit;
   logic [31:0]  vc_req_addr;
   logic [127:0] vc_req_data, vc_rsp_data;
   logic [31:0]  gnt_cnt_i, gnt_cnt_d, hit_cnt;
   logic         protocol_err;

   int checks = 0;
   int failures = 0;

   victim_cache_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .i_req_valid_i(i_req_valid), .i_req_evict_i(i_req_evict),
      .i_req_addr_i(i_req_addr), .i_req_data_i(i_req_data),
      .i_req_ready_o(i_req_ready), .i_rsp_valid_o(i_rsp_valid),
      .i_rsp_hit_o(i_rsp_hit), .i_rsp_data_o(i_rsp_data),
      .d_req_valid_i(d_req_valid), .d_req_evict_i(d_req_evict),
      .d_req_addr_i(d_req_addr), .d_req_data_i(d_req_data),
      .d_req_ready_o(d_req_ready), .d_rsp_valid_o(d_rsp_valid),
      .d_rsp_hit_o(d_rsp_hit), .d_rsp_data_o(d_rsp_data),
      .vc_req_valid_o(vc_req_valid), .vc_req_evict_o(vc_req_evict),
      .vc_req_addr_o(vc_req_addr), .vc_req_data_o(vc_req_data),
      .vc_req_ready_i(vc_req_ready), .vc_rsp_valid_i(vc_rsp_valid),
      .vc_rsp_hit_i(vc_rsp_hit), .vc_rsp_data_i(vc_rsp_data),
      .gnt_cnt_i_o(gnt_cnt_i), .gnt_cnt_d_o(gnt_cnt_d), .hit_cnt_o(hit_cnt),
      .protocol_err_o(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         req_i, req_d;
      logic         i_evict;
      logic [31:0]  i_addr;
      logic [127:0] i_data;
      logic         d_evict;
      logic [31:0]  d_addr;
      logic [127:0] d_data;
      int           stall, delay;
      logic         vc_hit;
      logic [127:0] vc_data;
      logic         own_d, exp_hit;
      logic [127:0] exp_data;
      logic [31:0]  exp_gi, exp_gd, exp_hc;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_req_valid = 1'b0; i_req_evict = 1'b0; i_req_addr = '0; i_req_data = '0;
      d_req_valid = 1'b0; d_req_evict = 1'b0; d_req_addr = '0; d_req_data = '0;
      vc_req_ready = 1'b0; vc_rsp_valid = 1'b0; vc_rsp_hit = 1'b0; vc_rsp_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      i_req_valid = v.req_i; i_req_evict = v.i_evict; i_req_addr = v.i_addr; i_req_data = v.i_data;
      d_req_valid = v.req_d; d_req_evict = v.d_evict; d_req_addr = v.d_addr; d_req_data = v.d_data;
      #1;
      chk($sformatf("v%0d i_ready", idx), i_req_ready, !v.own_d);
      chk($sformatf("v%0d d_ready", idx), d_req_ready, v.own_d);
      @(negedge clk);
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      vc_req_ready = (v.stall == 0);
      #1;
      chk($sformatf("v%0d vc_valid", idx), vc_req_valid, 1'b1);
      chk($sformatf("v%0d vc_evict", idx), vc_req_evict, v.own_d ? v.d_evict : v.i_evict);
      chk($sformatf("v%0d vc_addr", idx), vc_req_addr, v.own_d ? v.d_addr : v.i_addr);
      chk($sformatf("v%0d vc_data", idx), vc_req_data, v.own_d ? v.d_data : v.i_data);
      for (int s = 0; s < v.stall; s++) begin
         @(negedge clk);
         i_req_valid = 1'b1; d_req_valid = 1'b1;
         if (s == v.stall - 1) vc_req_ready = 1'b1;
         #1;
         chk($sformatf("v%0d stall%0d vc_valid", idx, s), vc_req_valid, 1'b1);
         chk($sformatf("v%0d stall%0d vc_addr", idx, s), vc_req_addr, v.own_d ? v.d_addr : v.i_addr);
         chk($sformatf("v%0d stall%0d vc_data", idx, s), vc_req_data, v.own_d ? v.d_data : v.i_data);
         chk($sformatf("v%0d stall%0d readies", idx, s), {i_req_ready, d_req_ready}, 2'b00);
      end
      @(negedge clk);
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      vc_req_ready = 1'b0;
      #1;
      chk($sformatf("v%0d wait vc_valid", idx), vc_req_valid, 1'b0);
      repeat (v.delay) @(negedge clk);
      vc_rsp_valid = 1'b1; vc_rsp_hit = v.vc_hit; vc_rsp_data = v.vc_data;
      @(negedge clk);
      vc_rsp_valid = 1'b0; vc_rsp_hit = 1'b0; vc_rsp_data = '0;
      #1;
      chk($sformatf("v%0d i_rsp_valid", idx), i_rsp_valid, !v.own_d);
      chk($sformatf("v%0d d_rsp_valid", idx), d_rsp_valid, v.own_d);
      chk($sformatf("v%0d i_rsp_hit", idx), i_rsp_hit, v.own_d ? 1'b0 : v.exp_hit);
      chk($sformatf("v%0d d_rsp_hit", idx), d_rsp_hit, v.own_d ? v.exp_hit : 1'b0);
      chk($sformatf("v%0d i_rsp_data", idx), i_rsp_data, v.own_d ? 128'h0 : v.exp_data);
      chk($sformatf("v%0d d_rsp_data", idx), d_rsp_data, v.own_d ? v.exp_data : 128'h0);
      chk($sformatf("v%0d gnt_i", idx), gnt_cnt_i, v.exp_gi);
      chk($sformatf("v%0d gnt_d", idx), gnt_cnt_d, v.exp_gd);
      chk($sformatf("v%0d hit_cnt", idx), hit_cnt, v.exp_hc);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d rsp_pulse_end", idx), {i_rsp_valid, d_rsp_valid}, 2'b00);
   endtask

   initial begin
      vec_t pe;
      int ni, nd;
      logic exp_d;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 128'h0, 1'b0, 32'h0, 128'h0, 0, 0,
                  1'b1, L_A5, 1'b0, 1'b1, L_A5, 32'd1, 32'd0, 32'd1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 128'h0, 1'b1, 32'h240, L_DEAD, 0, 2,
                  1'b1, 128'h1234, 1'b1, 1'b0, 128'h0, 32'd1, 32'd1, 32'd1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 128'h0, 1'b0, 32'h240, 128'h0, 1, 0,
                  1'b1, L_DEAD, 1'b1, 1'b1, L_DEAD, 32'd1, 32'd2, 32'd2};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h300, 128'h33, 1'b0, 32'h380, 128'h38, 2, 1,
                  1'b0, 128'h77, 1'b0, 1'b0, 128'h0, 32'd2, 32'd2, 32'd2};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h400, 128'h44, 1'b0, 32'h480, 128'h48, 5, 0,
                  1'b1, 128'h55, 1'b1, 1'b1, 128'h55, 32'd2, 32'd3, 32'd3};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h500, 128'h5E, 1'b0, 32'h0, 128'h0, 0, 0,
                  1'b0, 128'h0, 1'b0, 1'b0, 128'h0, 32'd3, 32'd3, 32'd3};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h600, 128'h66, 1'b0, 32'h680, 128'h68, 0, 3,
                  1'b0, 128'h99, 1'b1, 1'b0, 128'h0, 32'd3, 32'd4, 32'd3};
      pe      = '{1'b1, 1'b0, 1'b0, 32'h800, 128'h0, 1'b0, 32'h0, 128'h0, 0, 0,
                  1'b1, 128'hC0FFEE, 1'b0, 1'b1, 128'hC0FFEE, 32'd4, 32'd4, 32'd4};

      rst_n = 1'b0;
      idle_inputs();
      do_reset();
      #1;
      chk("reset readies", {i_req_ready, d_req_ready}, 2'b00);
      chk("reset vc_valid", vc_req_valid, 1'b0);
      chk("reset rsp", {i_rsp_valid, d_rsp_valid, i_rsp_hit, d_rsp_hit}, 4'b0);
      chk("reset vc_fields", {vc_req_evict, vc_req_addr, vc_req_data}, 161'h0);
      chk("reset counters", {gnt_cnt_i, gnt_cnt_d, hit_cnt}, 96'h0);
      chk("reset err", protocol_err, 1'b0);

      // Tie arbitration from reset: both requesters hold valid for 4 grants each.
      ni = 0; nd = 0;
      vc_req_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin
            i_req_valid = 1'b1; i_req_addr = 32'h1000;
            d_req_valid = 1'b1; d_req_addr = 32'h2000;
         end
         #1;
         exp_d = (k % 2 == 1);
         chk($sformatf("tie%0d i_ready", k), i_req_ready, !exp_d);
         chk($sformatf("tie%0d d_ready", k), d_req_ready, exp_d);
         if (exp_d) nd++; else ni++;
         @(negedge clk);
         if (ni == 4) i_req_valid = 1'b0;
         if (nd == 4) d_req_valid = 1'b0;
         #1;
         chk($sformatf("tie%0d vc_addr", k), vc_req_addr, exp_d ? 32'h2000 : 32'h1000);
         @(negedge clk);
         vc_rsp_valid = 1'b1;
         @(negedge clk);
         vc_rsp_valid = 1'b0;
         #1;
         chk($sformatf("tie%0d rsp_owner", k), {i_rsp_valid, d_rsp_valid}, exp_d ? 2'b01 : 2'b10);
      end
      chk("tie gnt_i", gnt_cnt_i, 32'd4);
      chk("tie gnt_d", gnt_cnt_d, 32'd4);
      chk("tie err", protocol_err, 1'b0);

      do_reset();
      for (int v = 0; v < 7; v++) run_vec(vecs[v], v);
      chk("vec err", protocol_err, 1'b0);

      // Stray completion while idle.
      @(negedge clk);
      vc_rsp_valid = 1'b1; vc_rsp_hit = 1'b1; vc_rsp_data = 128'hBAD;
      #1;
      chk("perr before edge", protocol_err, 1'b0);
      @(negedge clk);
      vc_rsp_valid = 1'b0; vc_rsp_hit = 1'b0; vc_rsp_data = '0;
      #1;
      chk("perr set", protocol_err, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("perr no_rsp%0d", k), {i_rsp_valid, d_rsp_valid}, 2'b00);
         @(negedge clk);
         #1;
      end
      chk("perr hit_cnt", hit_cnt, 32'd3);
      run_vec(pe, 100);
      chk("perr sticky", protocol_err, 1'b1);

      // Reset while waiting for the victim cache.
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = 32'h700;
      #1;
      chk("rw i_ready", i_req_ready, 1'b1);
      @(negedge clk);
      i_req_valid = 1'b0; vc_req_ready = 1'b1;
      @(negedge clk);
      vc_req_ready = 1'b0;
      #1;
      chk("rw in_wait", vc_req_valid, 1'b0);
      chk("rw gnt_i pre", gnt_cnt_i, 32'd5);
      rst_n = 1'b0;
      #1;
      chk("rw async err", protocol_err, 1'b0);
      chk("rw async gnt", {gnt_cnt_i, gnt_cnt_d, hit_cnt}, 96'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vc_rsp_valid = 1'b1; vc_rsp_hit = 1'b1; vc_rsp_data = L_A5;
      @(negedge clk);
      vc_rsp_valid = 1'b0; vc_rsp_hit = 1'b0; vc_rsp_data = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("rw no_rsp%0d", k), {i_rsp_valid, d_rsp_valid}, 2'b00);
         @(negedge clk);
      end
      #1;
      chk("rw err", protocol_err, 1'b1);
      chk("rw counters", {gnt_cnt_i, gnt_cnt_d, hit_cnt}, 96'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
